// File: rtl/adpll_cfg_master_pkg.sv
// Shared constants for the ADPLL configuration master: bus widths, register map,
// bring-up FSM states and default timing parameters.
package adpll_cfg_master_pkg;

    localparam int ADPLL_ADDR_W = 8;
    localparam int FCWW         = 26;

    localparam logic [ADPLL_ADDR_W-1:0] ADPLL_SOFT_RST = 8'h00;
    localparam logic [ADPLL_ADDR_W-1:0] ADPLL_FCW      = 8'h04;
    localparam logic [ADPLL_ADDR_W-1:0] ADPLL_MODE     = 8'h08;
    localparam logic [ADPLL_ADDR_W-1:0] ADPLL_EN       = 8'h0C;
    localparam logic [ADPLL_ADDR_W-1:0] ADPLL_LOCK     = 8'h10;
    localparam logic [ADPLL_ADDR_W-1:0] ADPLL_SAT      = 8'h14;

    localparam logic [31:0] ADPLL_EN_ON  = 32'd1;
    localparam logic [31:0] ADPLL_EN_OFF = 32'd0;

    localparam int DEF_POLL_GAP  = 64;
    localparam int DEF_MAX_POLLS = 1024;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_W_RST,
        ST_W_FCW,
        ST_W_MODE,
        ST_W_EN,
        ST_GAP,
        ST_R_LOCK,
        ST_R_SAT,
        ST_W_DIS,
        ST_FIN
    } cfg_state_e;

endpackage

// File: rtl/adpll_cfg_master_if.sv
// ADPLL CPU register bus: request (valid/address/wdata/wstrb) and response (rdata/ready).
interface adpll_cfg_master_if;
    import adpll_cfg_master_pkg::*;

    logic                    valid;
    logic [ADPLL_ADDR_W-1:0] address;
    logic [31:0]             wdata;
    logic                    wstrb;
    logic [31:0]             rdata;
    logic                    ready;

    modport master (output valid, address, wdata, wstrb, input rdata, ready);
    modport slave  (input valid, address, wdata, wstrb, output rdata, ready);

endinterface

// File: rtl/adpll_bus_master.sv
// Single-transaction bus engine: holds one request stable until ready, then drops valid.
// A new command is only accepted while valid is low, which guarantees the idle gap.
module adpll_bus_master
    import adpll_cfg_master_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_go,
    input  logic                    cmd_we,
    input  logic [ADPLL_ADDR_W-1:0] cmd_addr,
    input  logic [31:0]             cmd_wdata,
    output logic                    cmd_done,
    output logic [31:0]             cmd_rdata,
    adpll_cfg_master_if.master      bus
);

    logic                    valid_q, valid_d;
    logic                    we_q, we_d;
    logic [ADPLL_ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;

    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (valid_q) begin
            if (bus.ready) begin
                valid_d = 1'b0;
            end
        end else if (cmd_go) begin
            valid_d = 1'b1;
            we_d    = cmd_we;
            addr_d  = cmd_addr;
            wdata_d = cmd_we ? cmd_wdata : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign cmd_done    = valid_q & bus.ready;
    assign cmd_rdata   = bus.rdata;
    assign bus.valid   = valid_q;
    assign bus.wstrb   = we_q;
    assign bus.address = addr_q;
    assign bus.wdata   = wdata_q;

endmodule

// File: rtl/adpll_cfg_master.sv
// ADPLL channel bring-up sequencer: soft reset, FCW, mode, enable, then polls
// lock/saturation status until lock, timeout, saturation error or abort.
module adpll_cfg_master
    import adpll_cfg_master_pkg::*;
#(
    parameter int POLL_GAP  = DEF_POLL_GAP,
    parameter int MAX_POLLS = DEF_MAX_POLLS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [FCWW-1:0]   fcw_in,
    input  logic [1:0]        mode_in,
    adpll_cfg_master_if.master bus,
    output logic              busy,
    output logic              done,
    output logic              locked,
    output logic              timeout,
    output logic              sat_err
);

    localparam int POLL_W = $clog2(MAX_POLLS) + 1;
    localparam int GAP_W  = $clog2(POLL_GAP) + 1;
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(MAX_POLLS);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(POLL_GAP - 1);

    cfg_state_e        state_q, state_d;
    logic [FCWW-1:0]   fcw_q, fcw_d;
    logic [1:0]        mode_q, mode_d;
    logic [POLL_W-1:0] poll_q, poll_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              issued_q, issued_d;
    logic              abort_q, abort_d;
    logic              locked_q, locked_d;
    logic              timeout_q, timeout_d;
    logic              sat_q, sat_d;

    logic                    cmd_go, cmd_we, cmd_done;
    logic [ADPLL_ADDR_W-1:0] cmd_addr;
    logic [31:0]             cmd_wdata, cmd_rdata;
    logic                    abort_eff, rd_bit, rdata_unused;

    assign abort_eff    = abort_q | abort;
    assign rd_bit       = cmd_rdata[0];
    assign rdata_unused = ^cmd_rdata[31:1];

    adpll_bus_master u_bus (
        .clk       (clk),
        .rst       (rst),
        .cmd_go    (cmd_go),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_done  (cmd_done),
        .cmd_rdata (cmd_rdata),
        .bus       (bus)
    );

    // Register access implied by each bus state.
    always_comb begin
        cmd_we    = 1'b1;
        cmd_addr  = ADPLL_SOFT_RST;
        cmd_wdata = 32'd0;
        case (state_q)
            ST_W_RST:  cmd_wdata = 32'd1;
            ST_W_FCW:  begin cmd_addr = ADPLL_FCW;  cmd_wdata = 32'(fcw_q);  end
            ST_W_MODE: begin cmd_addr = ADPLL_MODE; cmd_wdata = 32'(mode_q); end
            ST_W_EN:   begin cmd_addr = ADPLL_EN;   cmd_wdata = ADPLL_EN_ON;  end
            ST_W_DIS:  begin cmd_addr = ADPLL_EN;   cmd_wdata = ADPLL_EN_OFF; end
            ST_R_LOCK: begin cmd_we = 1'b0; cmd_addr = ADPLL_LOCK; end
            ST_R_SAT:  begin cmd_we = 1'b0; cmd_addr = ADPLL_SAT;  end
            default:   ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        fcw_d     = fcw_q;
        mode_d    = mode_q;
        poll_d    = poll_q;
        gap_d     = gap_q;
        issued_d  = issued_q;
        abort_d   = abort_q;
        locked_d  = locked_q;
        timeout_d = timeout_q;
        sat_d     = sat_q;
        cmd_go    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    fcw_d     = fcw_in;
                    mode_d    = mode_in;
                    poll_d    = '0;
                    gap_d     = '0;
                    abort_d   = 1'b0;
                    locked_d  = 1'b0;
                    timeout_d = 1'b0;
                    sat_d     = 1'b0;
                    state_d   = ST_W_RST;
                end
            end
            ST_GAP: begin
                abort_d = abort_eff;
                if (abort_eff) begin
                    state_d = ST_W_DIS;
                end else if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = ST_R_LOCK;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_FIN: begin
                abort_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                // Bus states: issue once, then wait for the acknowledge.
                if (state_q != ST_W_DIS) begin
                    abort_d = abort_eff;
                end
                if (!issued_q) begin
                    if (abort_eff && state_q != ST_W_DIS) begin
                        state_d = ST_W_DIS;
                    end else begin
                        cmd_go   = 1'b1;
                        issued_d = 1'b1;
                    end
                end else if (cmd_done) begin
                    issued_d = 1'b0;
                    if (state_q == ST_R_LOCK) begin
                        poll_d = poll_q + 1'b1;
                    end
                    if (state_q == ST_W_DIS) begin
                        state_d = ST_FIN;
                    end else if (abort_eff) begin
                        state_d = ST_W_DIS;
                    end else begin
                        case (state_q)
                            ST_W_RST:  state_d = ST_W_FCW;
                            ST_W_FCW:  state_d = ST_W_MODE;
                            ST_W_MODE: state_d = ST_W_EN;
                            ST_W_EN:   state_d = ST_R_LOCK;
                            ST_R_LOCK: begin
                                if (rd_bit) begin
                                    state_d = ST_R_SAT;
                                end else if (poll_d == POLL_LAST) begin
                                    timeout_d = 1'b1;
                                    state_d   = ST_W_DIS;
                                end else begin
                                    gap_d   = '0;
                                    state_d = ST_GAP;
                                end
                            end
                            ST_R_SAT: begin
                                if (rd_bit) begin
                                    sat_d   = 1'b1;
                                    state_d = ST_W_DIS;
                                end else begin
                                    locked_d = 1'b1;
                                    state_d  = ST_FIN;
                                end
                            end
                            default: state_d = ST_IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            fcw_q     <= '0;
            mode_q    <= '0;
            poll_q    <= '0;
            gap_q     <= '0;
            issued_q  <= 1'b0;
            abort_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            fcw_q     <= fcw_d;
            mode_q    <= mode_d;
            poll_q    <= poll_d;
            gap_q     <= gap_d;
            issued_q  <= issued_d;
            abort_q   <= abort_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
            sat_q     <= sat_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_FIN);
    assign locked  = locked_q;
    assign timeout = timeout_q;
    assign sat_err = sat_q;

endmodule

// File: tb/tb_adpll_cfg_master.sv
// Bench for adpll_cfg_master: register-block responder with a lock-after-N model,
// an expected transaction list per scenario and a per-cycle protocol/result checker.
module tb_adpll_cfg_master;
    import adpll_cfg_master_pkg::*;

    localparam int TB_POLL_GAP  = 4;
    localparam int TB_MAX_POLLS = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [FCWW-1:0] fcw_in = '0;
    logic [1:0]      mode_in = '0;
    logic            busy, done, locked, timeout, sat_err;

    adpll_cfg_master_if bus_if ();

    adpll_cfg_master #(.POLL_GAP(TB_POLL_GAP), .MAX_POLLS(TB_MAX_POLLS)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .fcw_in  (fcw_in),
        .mode_in (mode_in),
        .bus     (bus_if),
        .busy    (busy),
        .done    (done),
        .locked  (locked),
        .timeout (timeout),
        .sat_err (sat_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scenario knobs for the responder: lock reported from read number lock_after
    // (0 = never), SAT value, and extra ready delay on the FCW write.
    int lock_after = 0;
    bit sat_val    = 1'b0;
    int fcw_delay  = 0;
    int wait_cnt;
    int lock_reads;

    function automatic logic resp_bit(input logic we, input logic [7:0] a, input int nreads);
        if (we) return 1'b0;
        if (a == ADPLL_LOCK) return (lock_after != 0) && (nreads + 1 >= lock_after);
        if (a == ADPLL_SAT) return sat_val;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            bus_if.ready <= 1'b0;
            bus_if.rdata <= 32'd0;
            wait_cnt     <= 0;
            lock_reads   <= 0;
        end else if (bus_if.ready) begin
            bus_if.ready <= 1'b0;
        end else if (bus_if.valid) begin
            if (bus_if.wstrb && bus_if.address == ADPLL_FCW && wait_cnt < fcw_delay) begin
                wait_cnt <= wait_cnt + 1;
            end else begin
                wait_cnt     <= 0;
                bus_if.ready <= 1'b1;
                bus_if.rdata <= ($urandom() & 32'hFFFF_FFFE)
                              | 32'(resp_bit(bus_if.wstrb, bus_if.address, lock_reads));
                if (!bus_if.wstrb && bus_if.address == ADPLL_LOCK) lock_reads <= lock_reads + 1;
            end
        end
    end

    // Expected behaviour: ordered list of {we, addr, data} plus final status flags.
    logic [40:0] exp_q[$];
    logic        exp_locked, exp_timeout, exp_sat;

    function automatic logic [40:0] txn(input logic we, input logic [7:0] a, input logic [31:0] d);
        return {we, a, d};
    endfunction

    task automatic push_bringup(input logic [FCWW-1:0] f, input logic [1:0] m);
        exp_q.delete();
        exp_q.push_back(txn(1'b1, ADPLL_SOFT_RST, 32'd1));
        exp_q.push_back(txn(1'b1, ADPLL_FCW, 32'(f)));
        exp_q.push_back(txn(1'b1, ADPLL_MODE, 32'(m)));
        exp_q.push_back(txn(1'b1, ADPLL_EN, 32'd1));
        exp_locked = 1'b0; exp_timeout = 1'b0; exp_sat = 1'b0;
    endtask

    task automatic model_expect(input logic [FCWW-1:0] f, input logic [1:0] m, input int la, input bit sv);
        bit hit;
        int nreads;
        push_bringup(f, m);
        hit    = (la != 0) && (la <= TB_MAX_POLLS);
        nreads = hit ? la : TB_MAX_POLLS;
        for (int i = 0; i < nreads; i++) exp_q.push_back(txn(1'b0, ADPLL_LOCK, 32'd0));
        if (!hit) begin
            exp_q.push_back(txn(1'b1, ADPLL_EN, 32'd0));
            exp_timeout = 1'b1;
        end else begin
            exp_q.push_back(txn(1'b0, ADPLL_SAT, 32'd0));
            if (sv) begin
                exp_q.push_back(txn(1'b1, ADPLL_EN, 32'd0));
                exp_sat = 1'b1;
            end else begin
                exp_locked = 1'b1;
            end
        end
    endtask

    // Per-cycle compare process.
    int done_cnt, n_lock, vlen, fcw_vlen, min_sp, last_lock, cyc;
    logic p_valid, p_ready, p_done;
    logic [40:0] p_req;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                done_cnt = 0; n_lock = 0; vlen = 0; fcw_vlen = 0;
                min_sp = 1000000; last_lock = -1; cyc = 0;
                p_valid = 1'b0; p_ready = 1'b0; p_done = 1'b0; p_req = '0;
            end else begin
                cyc++;
                if (p_valid && !p_ready && bus_if.valid)
                    check("bus_hold", {bus_if.wstrb, bus_if.address, bus_if.wdata}, p_req);
                if (p_valid && p_ready) check("bus_gap", bus_if.valid, 1'b0);
                if (bus_if.valid) check("busy_with_valid", busy, 1'b1);
                if (bus_if.valid && !p_valid) begin
                    vlen = 0;
                    if (!bus_if.wstrb && bus_if.address == ADPLL_LOCK) begin
                        if (last_lock >= 0 && cyc - last_lock < min_sp) min_sp = cyc - last_lock;
                        last_lock = cyc;
                    end
                end
                if (bus_if.valid) vlen++;
                if (bus_if.valid && bus_if.ready) begin
                    $display("[%0t] %s addr=0x%02h wdata=0x%08h rdata=0x%08h", $time,
                             bus_if.wstrb ? "WR" : "RD", bus_if.address, bus_if.wdata, bus_if.rdata);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL txn_unexpected: got addr 0x%02h we %0b, required no transaction",
                                 bus_if.address, bus_if.wstrb);
                    end else begin
                        check("txn", {bus_if.wstrb, bus_if.address, bus_if.wdata}, exp_q.pop_front());
                    end
                    if (!bus_if.wstrb && bus_if.address == ADPLL_LOCK) n_lock++;
                    if (bus_if.wstrb && bus_if.address == ADPLL_FCW) fcw_vlen = vlen;
                end
                if (p_done) check("done_pulse", done, 1'b0);
                if (done) begin
                    done_cnt++;
                    check("done_busy", busy, 1'b1);
                    check("done_flags", {locked, timeout, sat_err}, {exp_locked, exp_timeout, exp_sat});
                    check("done_all_txns", exp_q.size(), 0);
                end
                p_valid = bus_if.valid;
                p_ready = bus_if.ready;
                p_done  = done;
                p_req   = {bus_if.wstrb, bus_if.address, bus_if.wdata};
            end
        end
    end

    task automatic do_reset();
        #1 rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic pulse_start(input logic [FCWW-1:0] f, input logic [1:0] m, input logic ab);
        @(negedge clk);
        start = 1'b1; fcw_in = f; mode_in = m; abort = ab;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int i = 0;
        while (done_cnt == 0 && i < 3000) begin
            @(negedge clk);
            i++;
        end
        check({name, "_done_seen"}, (done_cnt != 0), 1'b1);
        repeat (2) @(negedge clk);
        check({name, "_idle_after"}, busy, 1'b0);
    endtask

    task automatic run_case(input string name, input logic [FCWW-1:0] f, input logic [1:0] m,
                            input int la, input bit sv, input int dly, input bit rst_first, input logic ab);
        lock_after = la; sat_val = sv; fcw_delay = dly;
        if (rst_first) do_reset();
        model_expect(f, m, la, sv);
        pulse_start(f, m, ab);
        wait_done(name);
    endtask

    initial begin
        int i;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", bus_if.valid, 1'b0);
        check("rst_busy_done", {busy, done}, 2'b00);
        check("rst_flags", {locked, timeout, sat_err}, 3'b000);
        rst = 1'b0;

        // Happy path: lock on the third read, no saturation.
        run_case("happy", 26'h2620000, 2'd2, 3, 1'b0, 0, 1'b1, 1'b0);
        check("happy_lock_reads", n_lock, 3);
        check("happy_flags", {locked, timeout, sat_err}, 3'b100);
        check("happy_lock_spacing", (min_sp >= TB_POLL_GAP + 3), 1'b1);
        check("happy_done_count", done_cnt, 1);

        // Timeout: lock never reported.
        run_case("timeout", 26'h0123456, 2'd1, 0, 1'b0, 0, 1'b1, 1'b0);
        check("timeout_lock_reads", n_lock, 4);
        check("timeout_flags", {locked, timeout, sat_err}, 3'b010);
        check("timeout_done_count", done_cnt, 1);

        // Saturation, with the FCW write acknowledged 5 cycles late.
        run_case("sat", 26'h3FFFFFF, 2'd3, 1, 1'b1, 5, 1'b1, 1'b0);
        check("sat_flags", {locked, timeout, sat_err}, 3'b001);
        check("sat_lock_reads", n_lock, 1);
        check("sat_fcw_valid_len", fcw_vlen, 7);

        // Abort during the poll gap, with a start attempted while busy.
        lock_after = 0; sat_val = 1'b0; fcw_delay = 0;
        do_reset();
        push_bringup(26'h0ABCDEF, 2'd0);
        exp_q.push_back(txn(1'b0, ADPLL_LOCK, 32'd0));
        exp_q.push_back(txn(1'b1, ADPLL_EN, 32'd0));
        pulse_start(26'h0ABCDEF, 2'd0, 1'b0);
        i = 0;
        while (n_lock < 1 && i < 500) begin @(negedge clk); i++; end
        check("abort_first_read_seen", n_lock, 1);
        @(posedge clk); #1;
        abort = 1'b1; start = 1'b1; fcw_in = 26'h1111111;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        wait_done("abort");
        check("abort_lock_reads", n_lock, 1);
        check("abort_flags", {locked, timeout, sat_err}, 3'b000);
        repeat (20) @(negedge clk);
        check("abort_no_rerun", {done_cnt[7:0], busy}, {8'd1, 1'b0});

        // Synchronous reset while the MODE write is outstanding.
        lock_after = 3;
        do_reset();
        model_expect(26'h2620000, 2'd2, 3, 1'b0);
        pulse_start(26'h2620000, 2'd2, 1'b0);
        i = 0;
        while (!(bus_if.valid && bus_if.wstrb && bus_if.address == ADPLL_MODE) && i < 200) begin
            @(negedge clk); i++;
        end
        check("mode_write_seen", bus_if.address, ADPLL_MODE);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_valid", bus_if.valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_flags", {locked, timeout, sat_err}, 3'b000);
        @(posedge clk); #1 rst = 1'b0;

        // Rerun from SOFT_RST; start and abort together in IDLE, start wins.
        run_case("rerun", 26'h2620000, 2'd2, 2, 1'b0, 0, 1'b0, 1'b1);
        check("rerun_lock_reads", n_lock, 2);
        check("rerun_flags", {locked, timeout, sat_err}, 3'b100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
